// File: rtl/seq_divider_if.sv
// seq_divider_if: start/ready/done handshake bundle for seq_divider.
// master drives operands, slave returns results.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

  modport master (
    output start,
    output is_signed,
    output a,
    output b,
    input  ready,
    input  done,
    input  q,
    input  r,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  is_signed,
    input  a,
    input  b,
    output ready,
    output done,
    output q,
    output r,
    output div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, IDLE/CALC/FIX FSM.
// Define SEQ_DIVIDER_SIGNED_EN to build two's-complement signed mode.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input logic         clock,
  input logic         reset_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_done;
  logic             r_dbz;

  logic             w_bz;
  logic             w_go;
  logic [WIDTH-1:0] w_ua;
  logic [WIDTH-1:0] w_ub;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH-1:0] w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_rnext;
  logic [WIDTH-1:0] w_qfix;
  logic [WIDTH-1:0] w_rfix;

  assign w_bz = (bus.b == '0);
  assign w_go = (r_state == S_IDLE) && bus.start;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_sq;
  logic r_sr;
  logic w_sgn;
  logic w_na;
  logic w_nb;

  assign w_sgn = bus.is_signed;
  assign w_na  = w_sgn & bus.a[WIDTH-1];
  assign w_nb  = w_sgn & bus.b[WIDTH-1];
  assign w_ua  = w_na ? -bus.a : bus.a;
  assign w_ub  = w_nb ? -bus.b : bus.b;

  // latch result signs at capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sq <= 1'b0;
      r_sr <= 1'b0;
    end else if (w_go) begin
      r_sq <= w_na ^ w_nb;
      r_sr <= w_na;
    end
  end

  assign w_qfix = r_sq ? -r_a : r_a;
  assign w_rfix = r_sr ? -r_rem : r_rem;
`else
  assign w_ua   = bus.a;
  assign w_ub   = bus.b;
  assign w_qfix = r_a;
  assign w_rfix = r_rem;
`endif

  // one restoring step; extra bit keeps the compare exact
  assign w_rsh   = {r_rem, r_a[WIDTH-1]};
  assign w_ge    = (w_rsh >= {1'b0, r_b});
  assign w_sub   = w_rsh[WIDTH-1:0] - r_b;
  assign w_rnext = w_ge ? w_sub : w_rsh[WIDTH-1:0];

  // FSM and datapath: capture, iterate, hand off to FIX
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_dz    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // raw dividend kept on b==0: it is the remainder
            r_a     <= w_bz ? bus.a : w_ua;
            r_b     <= w_ub;
            r_rem   <= '0;
            r_cnt   <= CNT_INIT;
            r_dz    <= w_bz;
            r_state <= w_bz ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          r_a   <= {r_a[WIDTH-2:0], w_ge};
          r_rem <= w_rnext;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // result registers: written only in FIX, held otherwise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
      r_q    <= '0;
      r_r    <= '0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      if (r_state == S_FIX) begin
        r_q   <= r_dz ? '1 : w_qfix;
        r_r   <= r_dz ? r_a : w_rfix;
        r_dbz <= r_dz;
      end
    end
  end

  assign bus.ready       = (r_state == S_IDLE);
  assign bus.done        = r_done;
  assign bus.q           = r_q;
  assign bus.r           = r_r;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed + random checks of seq_divider.
// 32-bit and 8-bit instances share clock and reset.
module tb_seq_divider;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   acc32 = 0;
  int   acc8  = 0;
  exp_t sb32[$];
  exp_t sb8[$];

  seq_divider_if #(.WIDTH(32)) bus32();
  seq_divider_if #(.WIDTH(8))  bus8();

  seq_divider #(.WIDTH(32)) u32 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus32)
  );

  seq_divider #(.WIDTH(8)) u8 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus8)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start32(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic s,
                         input bit push,
                         input logic [31:0] eq,
                         input logic [31:0] er,
                         input logic edz,
                         input int elat);
    exp_t e;
    @(negedge clk);
    bus32.start = 1'b1;
    bus32.a = a;
    bus32.b = b;
    bus32.is_signed = s;
    chk("ready32", {63'd0, bus32.ready}, 64'd1);
    if (push) begin
      e.q = {32'd0, eq};
      e.r = {32'd0, er};
      e.dz = edz;
      e.lat = elat;
      sb32.push_back(e);
    end
    @(posedge clk);
    #1;
    acc32 = cyc;
    bus32.start = 1'b0;
    bus32.a = $urandom;
    bus32.b = $urandom;
    bus32.is_signed = $urandom_range(0, 1) != 0;
  endtask

  task automatic start8(input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [7:0] eq,
                        input logic [7:0] er,
                        input int elat);
    exp_t e;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = a;
    bus8.b = b;
    bus8.is_signed = 1'b0;
    chk("ready8", {63'd0, bus8.ready}, 64'd1);
    e.q = {56'd0, eq};
    e.r = {56'd0, er};
    e.dz = 1'b0;
    e.lat = elat;
    sb8.push_back(e);
    @(posedge clk);
    #1;
    acc8 = cyc;
    bus8.start = 1'b0;
    bus8.a = 8'($urandom);
    bus8.b = 8'($urandom);
  endtask

  task automatic wait32(input string tag);
    int n;
    exp_t e;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus32.done !== 1'b1 && n < 100);
    if (bus32.done !== 1'b1) begin
      chk({tag, "_timeout"}, {63'd0, bus32.done}, 64'd1);
      if (sb32.size() != 0) void'(sb32.pop_front());
      return;
    end
    if (sb32.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb32.pop_front();
    chk({tag, "_q"}, {32'd0, bus32.q}, e.q);
    chk({tag, "_r"}, {32'd0, bus32.r}, e.r);
    chk({tag, "_dz"}, {63'd0, bus32.div_by_zero},
        {63'd0, e.dz});
    chk({tag, "_lat"}, 64'(cyc - acc32), 64'(e.lat));
  endtask

  task automatic wait8(input string tag);
    int n;
    exp_t e;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus8.done !== 1'b1 && n < 40);
    if (bus8.done !== 1'b1) begin
      chk({tag, "_timeout"}, {63'd0, bus8.done}, 64'd1);
      if (sb8.size() != 0) void'(sb8.pop_front());
      return;
    end
    if (sb8.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb8.pop_front();
    chk({tag, "_q"}, {56'd0, bus8.q}, e.q);
    chk({tag, "_r"}, {56'd0, bus8.r}, e.r);
    chk({tag, "_lat"}, 64'(cyc - acc8), 64'(e.lat));
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ready"}, {63'd0, bus32.ready}, 64'd1);
    chk({tag, "_done"}, {63'd0, bus32.done}, 64'd0);
    chk({tag, "_q"}, {32'd0, bus32.q}, 64'd0);
    chk({tag, "_r"}, {32'd0, bus32.r}, 64'd0);
    chk({tag, "_dz"}, {63'd0, bus32.div_by_zero}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int seen;
    bus32.start = 1'b0;
    bus32.is_signed = 1'b0;
    bus32.a = '0;
    bus32.b = '0;
    bus8.start = 1'b0;
    bus8.is_signed = 1'b0;
    bus8.a = '0;
    bus8.b = '0;

    #2 rst_n = 1'b0;
    #1 chk_rst("rst0");
    chk("rst0_ready8", {63'd0, bus8.ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    start32(32'd100, 32'd7, 1'b0, 1'b1,
            32'd14, 32'd2, 1'b0, 33);
    wait32("u100_7");
    @(posedge clk);
    #1 chk("done_1cyc", {63'd0, bus32.done}, 64'd0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    start32(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1,
            32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
`else
    start32(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1,
            32'h7FFFFFFC, 32'd1, 1'b0, 33);
`endif
    wait32("s_m7_2");

    start32(32'hFFFFFFF9, 32'd2, 1'b0, 1'b1,
            32'h7FFFFFFC, 32'd1, 1'b0, 33);
    wait32("u_m7_2");

    start32(32'd5, 32'd0, 1'b0, 1'b1,
            32'hFFFFFFFF, 32'd5, 1'b1, 1);
    wait32("dz5");

    start32(32'hFFFFFFF9, 32'd0, 1'b1, 1'b1,
            32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1);
    wait32("dz_neg");

    start32(32'd100, 32'd7, 1'b0, 1'b1,
            32'd14, 32'd2, 1'b0, 33);
    wait32("dz_clear");

`ifdef SEQ_DIVIDER_SIGNED_EN
    start32(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1,
            32'h80000000, 32'd0, 1'b0, 33);
`else
    start32(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1,
            32'd0, 32'h80000000, 1'b0, 33);
`endif
    wait32("ovf");

    start32(32'd100, 32'd7, 1'b0, 1'b1,
            32'd14, 32'd2, 1'b0, 33);
    repeat (5) @(negedge clk);
    bus32.start = 1'b1;
    bus32.a = 32'd9;
    bus32.b = 32'd3;
    chk("busy_ready", {63'd0, bus32.ready}, 64'd0);
    @(negedge clk);
    bus32.start = 1'b0;
    wait32("busy");

    start32(32'd100, 32'd7, 1'b0, 1'b0,
            32'd0, 32'd0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_rst("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus32.done === 1'b1) seen++;
    end
    chk("rst_no_done", 64'(seen), 64'd0);
    start32(32'd9, 32'd3, 1'b0, 1'b1,
            32'd3, 32'd0, 1'b0, 33);
    wait32("post_rst");

    start8(8'd255, 8'd16, 8'd15, 8'd15, 9);
    wait8("w8_255_16");
    start8(8'd200, 8'd3, 8'd66, 8'd2, 9);
    wait8("w8_b2b");

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 0) rb = 32'd1;
      start32(ra, rb, 1'b0, 1'b1,
              ra / rb, ra % rb, 1'b0, 33);
      wait32("rnd_u");
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    for (int i = 0; i < 4; i++) begin
      int sa;
      int sd;
      sa = $signed($urandom);
      sd = int'($urandom_range(1, 5000));
      if (i[0]) sd = -sd;
      start32(sa, sd, 1'b1, 1'b1,
              sa / sd, sa % sd, 1'b0, 33);
      wait32("rnd_s");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
